// File: rtl/arb_client.sv
// arb_client: 2-entry command queue driving an arbiter's req/done/dly
// handshake, with beat counting, post-transfer hold and timeout retry.
module arb_client #(
    parameter int MAX_RETRY   = 2,
    parameter int BACKOFF_CYC = 3,
    parameter int HOLD_CYC    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_len,
    input  logic       cmd_hold,
    output logic       cmd_ready,
    input  logic       gnt,
    input  logic       tout,
    output logic       req,
    output logic       done,
    output logic       dly,
    output logic       beat_valid,
    output logic       xfer_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;

    localparam logic [7:0]  MAXR = 8'(MAX_RETRY);
    localparam logic [15:0] BO   = 16'(BACKOFF_CYC);
    localparam logic [15:0] HC   = 16'(HOLD_CYC);

    logic [3:0]  q_len [2];
    logic        q_hold [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic [2:0]  state;
    logic [3:0]  rem;
    logic [7:0]  retry;
    logic [15:0] bo_cnt;
    logic [15:0] hold_cnt;

    logic [3:0]  head_len;
    logic        head_hold;
    logic [7:0]  retry_nx;
    logic        abort;
    logic        give_up;
    logic        push;
    logic        pop;

    assign cmd_ready = (count != 2'd2);
    assign push      = cmd_valid & cmd_ready;
    assign head_len  = (q_len[rd_ptr] == 4'd0) ? 4'd1 : q_len[rd_ptr];
    assign head_hold = q_hold[rd_ptr];
    assign retry_nx  = retry + 8'd1;
    assign abort     = tout & ((state == S_REQ) | (state == S_XFER));
    assign give_up   = abort & (retry_nx == MAXR);

    // Entry leaves the queue on completion (with or without hold) or on give-up
    assign pop = give_up
               | (!abort && state == S_XFER && rem == 4'd0 && !head_hold)
               | (state == S_HOLD && hold_cnt == HC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_len[0]  <= 4'd0;
            q_len[1]  <= 4'd0;
            q_hold[0] <= 1'b0;
            q_hold[1] <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                q_len[wr_ptr]  <= cmd_len;
                q_hold[wr_ptr] <= cmd_hold;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rem        <= 4'd0;
            retry      <= 8'd0;
            bo_cnt     <= 16'd0;
            hold_cnt   <= 16'd0;
            req        <= 1'b0;
            done       <= 1'b0;
            dly        <= 1'b0;
            beat_valid <= 1'b0;
            xfer_err   <= 1'b0;
        end else begin
            xfer_err <= 1'b0;
            if (abort) begin
                req        <= 1'b0;
                done       <= 1'b0;
                dly        <= 1'b0;
                beat_valid <= 1'b0;
                retry      <= retry_nx;
                rem        <= head_len;
                if (give_up) begin
                    xfer_err <= 1'b1;
                    state    <= S_IDLE;
                end else begin
                    bo_cnt <= 16'd1;
                    state  <= S_BACKOFF;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (count != 2'd0) begin
                            state <= S_REQ;
                            req   <= 1'b1;
                            rem   <= head_len;
                            retry <= 8'd0;
                        end
                    end
                    S_REQ: begin
                        if (gnt) begin
                            state      <= S_XFER;
                            req        <= 1'b0;
                            beat_valid <= 1'b1;
                            rem        <= rem - 4'd1;
                            done       <= (rem == 4'd1);
                            dly        <= head_hold & (rem == 4'd1);
                        end
                    end
                    S_XFER: begin
                        // rem counts beats not yet issued
                        if (rem == 4'd0) begin
                            beat_valid <= 1'b0;
                            done       <= 1'b0;
                            if (head_hold) begin
                                dly      <= 1'b1;
                                hold_cnt <= 16'd1;
                                state    <= S_HOLD;
                            end else begin
                                dly   <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else if (gnt) begin
                            beat_valid <= 1'b1;
                            rem        <= rem - 4'd1;
                            done       <= (rem == 4'd1);
                            dly        <= head_hold & (rem == 4'd1);
                        end else begin
                            beat_valid <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt == HC) begin
                            dly   <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                    S_BACKOFF: begin
                        if (bo_cnt == BO) begin
                            req   <= 1'b1;
                            state <= S_REQ;
                        end else begin
                            bo_cnt <= bo_cnt + 16'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
